// File: rtl/execute_pkg.sv
// Shared Y86-64 encodings, condition-code layout and multiplier state for the execute stage.
// Optional MUL support is enabled by defining EXEC_MUL_EN.
package execute_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] ALUADD = 4'h0;
  localparam logic [3:0] ALUSUB = 4'h1;
  localparam logic [3:0] ALUAND = 4'h2;
  localparam logic [3:0] ALUXOR = 4'h3;
  localparam logic [3:0] ALUMUL = 4'h4;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] SAOK = 4'h1;
  localparam logic [3:0] SADR = 4'h2;
  localparam logic [3:0] SINS = 4'h3;
  localparam logic [3:0] SHLT = 4'h4;

  localparam logic [3:0] RNONE = 4'hF;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;
  localparam logic [2:0] CC_RESET = 3'b100;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_RUN,
    MUL_DONE
  } mul_state_e;

  function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
    logic zf, sf, of;
    zf = cc[CC_ZF];
    sf = cc[CC_SF];
    of = cc[CC_OF];
    case (ifun)
      C_YES:   cond_eval = 1'b1;
      C_LE:    cond_eval = (sf ^ of) | zf;
      C_L:     cond_eval = sf ^ of;
      C_E:     cond_eval = zf;
      C_NE:    cond_eval = ~zf;
      C_GE:    cond_eval = ~(sf ^ of);
      C_G:     cond_eval = ~(sf ^ of) & ~zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/execute_if.sv
// Bundle of the execute pipeline-register inputs and execute-stage results.
interface execute_if;
  logic [3:0]  E_stat;
  logic [3:0]  E_icode;
  logic [3:0]  E_ifun;
  logic [3:0]  E_dstE;
  logic [63:0] E_valC;
  logic [63:0] E_valA;
  logic [63:0] E_valB;
  logic [3:0]  m_stat;
  logic [3:0]  W_stat;
  logic [63:0] e_valE;
  logic        e_Cnd;
  logic [3:0]  e_dstE;
  logic [2:0]  e_cc;
  logic        e_busy;

  modport master (
    output E_stat, E_icode, E_ifun, E_dstE, E_valC, E_valA, E_valB, m_stat, W_stat,
    input  e_valE, e_Cnd, e_dstE, e_cc, e_busy
  );

  modport slave (
    input  E_stat, E_icode, E_ifun, E_dstE, E_valC, E_valA, E_valB, m_stat, W_stat,
    output e_valE, e_Cnd, e_dstE, e_cc, e_busy
  );
endinterface

// File: rtl/execute_alu.sv
// Combinational single-cycle ALU: add/sub/and/xor with ZF/SF/OF; fun_ok flags a defined op.
module execute_alu
  import execute_pkg::*;
(
  input  logic [63:0] alu_a,
  input  logic [63:0] alu_b,
  input  logic [3:0]  alu_fun,
  output logic [63:0] result,
  output logic        zf,
  output logic        sf,
  output logic        of,
  output logic        fun_ok
);

  // Overflow: operands effectively share a sign but the result sign differs.
  always_comb begin
    result = '0;
    of     = 1'b0;
    fun_ok = 1'b1;
    case (alu_fun)
      ALUADD: begin
        result = alu_b + alu_a;
        of     = (alu_a[63] == alu_b[63]) && (result[63] != alu_b[63]);
      end
      ALUSUB: begin
        result = alu_b - alu_a;
        of     = (alu_a[63] != alu_b[63]) && (result[63] != alu_b[63]);
      end
      ALUAND:  result = alu_b & alu_a;
      ALUXOR:  result = alu_b ^ alu_a;
      default: fun_ok = 1'b0;
    endcase
    zf = (result == 64'd0);
    sf = result[63];
  end

endmodule

// File: rtl/execute.sv
// Y86-64 execute stage: ALU operand select, CC register, branch/cmov condition.
// Define EXEC_MUL_EN to add an iterative 64-cycle shift-add MUL (IOPQ ifun 4).
module execute
  import execute_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [3:0]  E_stat_i,
  input  logic [3:0]  E_icode_i,
  input  logic [3:0]  E_ifun_i,
  input  logic [3:0]  E_dstE_i,
  input  logic [63:0] E_valC_i,
  input  logic [63:0] E_valA_i,
  input  logic [63:0] E_valB_i,
  input  logic [3:0]  m_stat_i,
  input  logic [3:0]  W_stat_i,
  output logic [63:0] e_valE_o,
  output logic        e_Cnd_o,
  output logic [3:0]  e_dstE_o,
  output logic [2:0]  e_cc_o,
  output logic        e_busy_o
);

  logic [63:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_fun;
  logic        alu_zf, alu_sf, alu_of, alu_fun_ok;
  logic [2:0]  cc_q, cc_d, cc_new;
  logic        cc_load;
  logic [63:0] val_e;
  logic        is_opq, is_mul, stat_ok;
  logic        mul_busy, mul_done;
  logic [63:0] mul_acc;

  assign is_opq  = (E_icode_i == IOPQ);
  assign is_mul  = is_opq && (E_ifun_i == ALUMUL);
  assign stat_ok = (m_stat_i == SAOK) && (W_stat_i == SAOK);

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (E_icode_i)
      IRRMOVQ, IOPQ:            alu_a = E_valA_i;
      IIRMOVQ, IRMMOVQ, IMRMOVQ: alu_a = E_valC_i;
      ICALL, IPUSHQ:            alu_a = -64'sd8;
      IRET, IPOPQ:              alu_a = 64'd8;
      default:                  alu_a = '0;
    endcase
    case (E_icode_i)
      IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IPUSHQ, IRET, IPOPQ: alu_b = E_valB_i;
      default:                                           alu_b = '0;
    endcase
    alu_fun = is_opq ? E_ifun_i : ALUADD;
  end

  execute_alu alu (
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_fun (alu_fun),
    .result  (alu_result),
    .zf      (alu_zf),
    .sf      (alu_sf),
    .of      (alu_of),
    .fun_ok  (alu_fun_ok)
  );

`ifdef EXEC_MUL_EN
  mul_state_e  mul_state_q, mul_state_d;
  logic [63:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        mul_start;

  // Busy is raised in the accepting IDLE cycle itself so hazard control freezes E at once.
  assign mul_start = rstn_i && (mul_state_q == MUL_IDLE) && is_mul && (E_stat_i == SAOK);
  assign mul_busy  = mul_start || (mul_state_q == MUL_RUN);
  assign mul_done  = (mul_state_q == MUL_DONE);
  assign mul_acc   = acc_q;

  always_comb begin
    mul_state_d = mul_state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    case (mul_state_q)
      MUL_IDLE: begin
        if (mul_start) begin
          mul_state_d = MUL_RUN;
          acc_d       = '0;
          mcand_d     = alu_b;
          mplier_d    = alu_a;
          cnt_d       = '0;
        end
      end
      MUL_RUN: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == 6'd63) mul_state_d = MUL_DONE;
      end
      MUL_DONE: mul_state_d = MUL_IDLE;
      default:  mul_state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mul_state_q <= MUL_IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      mul_state_q <= mul_state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
    end
  end
`else
  logic unused_stat;
  assign unused_stat = ^E_stat_i;
  assign mul_busy    = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_acc     = '0;
`endif

  // An undefined IOPQ function yields zero and leaves CC alone; MUL writes CC only in DONE.
  always_comb begin
    val_e          = alu_result;
    cc_new         = '0;
    cc_new[CC_ZF]  = alu_zf;
    cc_new[CC_SF]  = alu_sf;
    cc_new[CC_OF]  = alu_of;
    cc_load        = is_opq && alu_fun_ok && stat_ok;
    if (is_opq && !alu_fun_ok) val_e = '0;
    if (mul_done && is_mul) begin
      val_e         = mul_acc;
      cc_new[CC_ZF] = (mul_acc == 64'd0);
      cc_new[CC_SF] = mul_acc[63];
      cc_new[CC_OF] = 1'b0;
      cc_load       = stat_ok;
    end
    cc_d = cc_load ? cc_new : cc_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) cc_q <= CC_RESET;
    else         cc_q <= cc_d;
  end

  assign e_valE_o = val_e;
  assign e_Cnd_o  = cond_eval(E_ifun_i, cc_q);
  assign e_dstE_o = ((E_icode_i == IRRMOVQ) && !e_Cnd_o) ? RNONE : E_dstE_i;
  assign e_cc_o   = cc_q;
  assign e_busy_o = mul_busy;

endmodule
